// File: rtl/tinker_mem_pkg.sv
// Shared types for the Tinker memory responder.
// Op codes, FSM states and access sizes.
package tinker_mem_pkg;

    typedef enum logic [1:0] {
        OP_IFETCH = 2'd0,
        OP_LOAD   = 2'd1,
        OP_STORE  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int IFETCH_BYTES = 4;
    localparam int DATA_BYTES   = 8;

endpackage

// File: rtl/tinker_mem_lat_ctr.sv
// Loadable latency down-counter; term flags the last WAIT cycle.
module tinker_mem_lat_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         term
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign term = (count == W'(1));

endmodule

// File: rtl/tinker_mem_responder.sv
// Big-endian byte store answering one request at a time with fixed latency.
// Optional alignment checking: define TINKER_MEM_ALIGN_CHECK_EN.
module tinker_mem_responder
    import tinker_mem_pkg::*;
#(
    parameter int MEM_SIZE = 524288,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(MEM_SIZE);

    logic [7:0] bytes [0:MEM_SIZE-1];

    state_e state_q, state_d;
    op_e          op_q;
    logic [63:0]  addr_q, wdata_q, rdata_q;
    logic         err_q;

    logic         accept, enter_resp, term;
    op_e          cur_op;
    logic [63:0]  cur_addr, cur_wdata;
    logic [3:0]   size;
    logic [64:0]  end_addr;
    logic         misalign, err;
    logic [AW-1:0] idx;
    logic [63:0]  ld_data, rd_next;
    logic [31:0]  if_data;

    // With LATENCY==1 RESP is entered on the accept edge, so use live inputs
    always_comb begin
        cur_op    = (state_q == ST_IDLE) ? op_e'(req_op) : op_q;
        cur_addr  = (state_q == ST_IDLE) ? req_addr : addr_q;
        cur_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    end

    always_comb begin
        size = (cur_op == OP_IFETCH) ? 4'(IFETCH_BYTES) : 4'(DATA_BYTES);
        end_addr = {1'b0, cur_addr} + 65'(size);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
        misalign = (cur_op == OP_IFETCH) ? (|cur_addr[1:0])
                                         : (|cur_addr[2:0]);
`else
        misalign = 1'b0;
`endif
        err = (end_addr > 65'(MEM_SIZE)) || (cur_op == OP_RSVD) || misalign;
        idx = cur_addr[AW-1:0];
    end

    always_comb begin
        ld_data = '0;
        if_data = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            ld_data[63-8*i -: 8] = bytes[idx + AW'(i)];
        for (int i = 0; i < IFETCH_BYTES; i++)
            if_data[31-8*i -: 8] = bytes[idx + AW'(i)];
        rd_next = '0;
        if (!err) begin
            if (cur_op == OP_LOAD)
                rd_next = ld_data;
            else if (cur_op == OP_IFETCH)
                rd_next = {32'b0, if_data};
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept  = 1'b1;
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: if (term) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        enter_resp = (state_q != ST_RESP) && (state_d == ST_RESP);
    end

    tinker_mem_lat_ctr #(.W(4)) u_lat_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (4'(LATENCY - 1)),
        .en       (state_q == ST_WAIT),
        .term     (term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_IFETCH;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= cur_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                rdata_q <= rd_next;
                err_q   <= err;
            end
        end
    end

    // Storage is not reset; the reset gate keeps an aborted STORE unwritten
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_op == OP_STORE && !err) begin
            for (int i = 0; i < DATA_BYTES; i++)
                bytes[idx + AW'(i)] <= cur_wdata[63-8*i -: 8];
        end
    end

    assign req_ready = reset && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_tinker_mem_responder.sv
// Directed scoreboard bench for tinker_mem_responder.
module tb_tinker_mem_responder;

    localparam int MEM_SIZE = 524288;
    localparam int LAT      = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        mon_en = 1'b0;
    int          acc_q[$];
    logic [63:0] got_q[$];

    tinker_mem_responder #(
        .MEM_SIZE (MEM_SIZE),
        .LATENCY  (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (mon_en) begin
            if (req_valid && req_ready) acc_q.push_back(cyc);
            if (rsp_valid && rsp_ready) got_q.push_back(rsp_rdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic xact(input string tag, input logic [1:0] op,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] erd, input logic eerr,
                        input int hold);
        int lat;
        logic [63:0] snap;
        exp_t e;
        sb.push_back('{rdata: erd, err: eerr});
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_acc"}, 64'(req_ready), 64'(1));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        snap = rsp_rdata;
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hv"}, 64'(rsp_valid), 64'(1));
            chk({tag, "_hd"}, rsp_rdata, snap);
            chk({tag, "_hr"}, 64'(req_ready), 64'(0));
        end
        e = sb.pop_front();
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, 64'(rsp_err), 64'(e.err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_drop"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] misal_rd;
        logic        misal_err;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", 64'(req_ready), 64'(0));
        chk("rst_vld", 64'(rsp_valid), 64'(0));
        chk("rst_rd", rsp_rdata, 64'(0));
        chk("rst_err", 64'(rsp_err), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("idle_rdy", 64'(req_ready), 64'(1));

        // Aborted STORE must leave prior contents intact
        xact("pre", 2'd2, 64'h3000, 64'h1111_1111_1111_1111, 64'h0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'd2;
        req_addr  = 64'h3000;
        req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_wait", 64'(req_ready), 64'(0));
        reset = 1'b0;
        #1;
        chk("abort_vld", 64'(rsp_valid), 64'(0));
        repeat (3) @(negedge clk);
        chk("abort_vld2", 64'(rsp_valid), 64'(0));
        reset = 1'b1;
        xact("post", 2'd1, 64'h3000, 64'h0, 64'h1111_1111_1111_1111, 1'b0, 0);

        xact("st", 2'd2, 64'h2000, 64'h0102_0304_0506_0708, 64'h0, 1'b0, 0);
        chk("b2000", 64'(dut.bytes[32'h2000]), 64'h01);
        chk("b2007", 64'(dut.bytes[32'h2007]), 64'h08);
        xact("ld", 2'd1, 64'h2000, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 5);
        xact("if", 2'd0, 64'h2004, 64'h0, 64'h0000_0000_0506_0708, 1'b0, 0);

        xact("oob", 2'd1, 64'(MEM_SIZE - 4), 64'h0, 64'h0, 1'b1, 0);
        xact("wrap", 2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0, 1'b1, 0);
        xact("stend", 2'd2, 64'(MEM_SIZE - 8), 64'h8877_6655_4433_2211,
             64'h0, 1'b0, 0);
        xact("ldend", 2'd1, 64'(MEM_SIZE - 8), 64'h0,
             64'h8877_6655_4433_2211, 1'b0, 0);
        xact("ifend", 2'd0, 64'(MEM_SIZE - 4), 64'h0,
             64'h0000_0000_4433_2211, 1'b0, 0);

        xact("st8", 2'd2, 64'h2008, 64'h1112_1314_1516_1718, 64'h0, 1'b0, 0);
        xact("rsvd", 2'd3, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0);
        xact("rsvchk", 2'd1, 64'h2000, 64'h0, 64'h0102_0304_0506_0708, 1'b0, 0);
`ifdef TINKER_MEM_ALIGN_CHECK_EN
        misal_rd  = 64'h0;
        misal_err = 1'b1;
`else
        misal_rd  = 64'h0506_0708_1112_1314;
        misal_err = 1'b0;
`endif
        xact("mis", 2'd1, 64'h2004, 64'h0, misal_rd, misal_err, 0);

        // Back-to-back: period of LAT+1 cycles including the idle bubble
        @(negedge clk);
        mon_en    = 1'b1;
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 64'h2000;
        rsp_ready = 1'b1;
        repeat (12) @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        mon_en    = 1'b0;
        chk("b2b_acc", 64'(acc_q.size()), 64'(3));
        chk("b2b_rsp", 64'(got_q.size()), 64'(3));
        for (int i = 1; i < acc_q.size(); i++)
            chk("b2b_gap", 64'(acc_q[i] - acc_q[i-1]), 64'(LAT + 1));
        foreach (got_q[i])
            chk("b2b_data", got_q[i], 64'h0102_0304_0506_0708);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
